// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory (separate write and read ports) between an
// instruction-fetch read client and a data load/store client.
//   clk, reset          : sole clock, asynchronous active-high reset
//   if_addr/if_valid    : fetch request in; if_ready/if_data : completion/read data out
//   d_addr/d_wdata/d_we/d_valid : load/store request in; d_ready/d_rdata : completion out
//   mem_in_*            : memory write port (addr, data, valid out; ready in)
//   mem_out_*           : memory read port (addr, valid out; ready, data in)
// One transaction is in flight at a time, with one IDLE cycle between transactions.
module memory_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   // instruction-fetch read port
   input  logic [31:0] if_addr,
   input  logic        if_valid,
   output logic        if_ready,
   output logic [31:0] if_data,
   // data load/store port
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_we,
   input  logic        d_valid,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   // memory write port
   output logic [31:0] mem_in_addr,
   output logic [31:0] mem_in_data,
   output logic        mem_in_valid,
   input  logic        mem_in_ready,
   // memory read port
   output logic [31:0] mem_out_addr,
   output logic        mem_out_valid,
   input  logic        mem_out_ready,
   input  logic [31:0] mem_out_data
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_LOAD  = 2'd2,
      ST_STORE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              last_data_q, last_data_d;   // 1 = data client was granted last
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              grant_data;

   // State and request registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         last_data_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         last_data_q <= last_data_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   // Arbitration and transaction sequencing
   always_comb begin
      state_d     = state_q;
      last_data_d = last_data_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      grant_data  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Data wins when alone, when fixed-priority, or when fetch was served last.
            grant_data = d_valid && (!if_valid || !ROUND_ROBIN || !last_data_q);
            if (grant_data) begin
               addr_d = d_addr;
               if (d_we) begin
                  state_d = ST_STORE;
                  wdata_d = d_wdata;
               end else begin
                  state_d = ST_LOAD;
               end
            end else if (if_valid) begin
               addr_d  = if_addr;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (mem_out_ready) begin
               state_d     = ST_IDLE;
               last_data_d = 1'b0;
            end
         end
         ST_LOAD: begin
            if (mem_out_ready) begin
               state_d     = ST_IDLE;
               last_data_d = 1'b1;
            end
         end
         ST_STORE: begin
            if (mem_in_ready) begin
               state_d     = ST_IDLE;
               last_data_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Memory side: valids decode the state, address/data only from request registers
   assign mem_out_valid = (state_q == ST_FETCH) || (state_q == ST_LOAD);
   assign mem_in_valid  = (state_q == ST_STORE);
   assign mem_out_addr  = addr_q;
   assign mem_in_addr   = addr_q;
   assign mem_in_data   = wdata_q;

   // Client side: ready follows only the memory port owned by the current state
   assign if_ready = (state_q == ST_FETCH) && mem_out_ready;
   assign d_ready  = ((state_q == ST_LOAD) && mem_out_ready) ||
                     ((state_q == ST_STORE) && mem_in_ready);
   assign if_data  = mem_out_data;
   assign d_rdata  = mem_out_data;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] if_addr;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_data;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_we;
   logic        d_valid;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic [31:0] mem_in_addr;
   logic [31:0] mem_in_data;
   logic        mem_in_valid;
   logic        mem_in_ready;
   logic [31:0] mem_out_addr;
   logic        mem_out_valid;
   logic        mem_out_ready;
   logic [31:0] mem_out_data;

   // fixed-priority instance, same clients, always-ready memory
   logic        fp_if_ready;
   logic [31:0] fp_if_data;
   logic        fp_d_ready;
   logic [31:0] fp_d_rdata;
   logic [31:0] fp_mem_in_addr;
   logic [31:0] fp_mem_in_data;
   logic        fp_mem_in_valid;
   logic [31:0] fp_mem_out_addr;
   logic        fp_mem_out_valid;

   int          checks = 0;
   int          errors = 0;

   // memory model state
   logic [31:0] mem_arr [0:255];
   logic        mem_rdy_q;
   int          mem_cnt;
   int          lat;
   logic        force_in_rdy;

   // monitors
   bit          overlap_seen = 1'b0;
   bit          log_en;
   bit          rr_log [$];
   int          d_cnt = 0;
   int          fp_d_cnt = 0;
   int          fp_if_cnt = 0;
   bit          fp_if_while_dv = 1'b0;

   memory_arbiter #(.ROUND_ROBIN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .if_addr(if_addr), .if_valid(if_valid), .if_ready(if_ready), .if_data(if_data),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_valid(d_valid),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_in_addr(mem_in_addr), .mem_in_data(mem_in_data),
      .mem_in_valid(mem_in_valid), .mem_in_ready(mem_in_ready),
      .mem_out_addr(mem_out_addr), .mem_out_valid(mem_out_valid),
      .mem_out_ready(mem_out_ready), .mem_out_data(mem_out_data)
   );

   memory_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
      .clk(clk), .reset(reset),
      .if_addr(if_addr), .if_valid(if_valid), .if_ready(fp_if_ready), .if_data(fp_if_data),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_valid(d_valid),
      .d_ready(fp_d_ready), .d_rdata(fp_d_rdata),
      .mem_in_addr(fp_mem_in_addr), .mem_in_data(fp_mem_in_data),
      .mem_in_valid(fp_mem_in_valid), .mem_in_ready(1'b1),
      .mem_out_addr(fp_mem_out_addr), .mem_out_valid(fp_mem_out_valid),
      .mem_out_ready(1'b1), .mem_out_data(32'h0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory with 'lat' cycles from first seen valid to ready; write on handshake
   assign mem_out_ready = mem_rdy_q & mem_out_valid;
   assign mem_in_ready  = (mem_rdy_q & mem_in_valid) | force_in_rdy;
   assign mem_out_data  = mem_arr[mem_out_addr[9:2]];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_rdy_q <= 1'b0;
         mem_cnt   <= 0;
      end else if (mem_rdy_q) begin
         mem_rdy_q <= 1'b0;
         mem_cnt   <= 0;
         if (mem_in_valid) mem_arr[mem_in_addr[9:2]] <= mem_in_data;
      end else if (mem_out_valid || mem_in_valid) begin
         if (mem_cnt == lat - 1) mem_rdy_q <= 1'b1;
         else                    mem_cnt   <= mem_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if ((mem_in_valid && mem_out_valid) || (fp_mem_in_valid && fp_mem_out_valid))
         overlap_seen <= 1'b1;
      if (d_ready) d_cnt <= d_cnt + 1;
      if (log_en) begin
         if (d_ready)  rr_log.push_back(1'b1);
         if (if_ready) rr_log.push_back(1'b0);
         if (fp_d_ready) fp_d_cnt <= fp_d_cnt + 1;
         if (fp_if_ready) begin
            fp_if_cnt <= fp_if_cnt + 1;
            if (d_valid) fp_if_while_dv <= 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for the client ready; index 0 is the first negedge after the call
   task automatic wait_ready(input bit is_data, input logic [31:0] exp_addr,
                             output int cyc, output logic [31:0] data, output bit addr_ok);
      cyc     = -1;
      data    = '0;
      addr_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((mem_out_valid || mem_in_valid) && (mem_out_addr !== exp_addr))
            addr_ok = 1'b0;
         if ((is_data ? d_ready : if_ready) === 1'b1) begin
            cyc  = i;
            data = is_data ? d_rdata : if_data;
            break;
         end
      end
   endtask

   int          cyc;
   logic [31:0] data;
   bit          aok;
   int          snap;

   initial begin
      reset = 1'b1; if_addr = '0; if_valid = 1'b0; d_addr = '0; d_wdata = '0;
      d_we = 1'b0; d_valid = 1'b0; lat = 1; force_in_rdy = 1'b0; log_en = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("rst_mem_out_valid", 32'(mem_out_valid), 32'd0);
      check("rst_mem_in_valid",  32'(mem_in_valid),  32'd0);
      check("rst_if_ready",      32'(if_ready),      32'd0);
      check("rst_d_ready",       32'(d_ready),       32'd0);
      check("rst_mem_out_addr",  mem_out_addr,       32'd0);
      check("rst_mem_in_data",   mem_in_data,        32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // store 36 <- 0xefefefef, 1-cycle memory
      d_addr = 32'd36; d_wdata = 32'hefefefef; d_we = 1'b1; d_valid = 1'b1;
      wait_ready(1'b1, 32'd36, cyc, data, aok);
      check("st_latency",       32'(cyc),            32'd2);
      check("st_mem_in_valid",  32'(mem_in_valid),   32'd1);
      check("st_mem_out_valid", 32'(mem_out_valid),  32'd0);
      check("st_mem_in_addr",   mem_in_addr,         32'd36);
      check("st_mem_in_data",   mem_in_data,         32'hefefefef);
      @(posedge clk); #1; d_valid = 1'b0; d_we = 1'b0;
      @(negedge clk);
      check("st_ready_pulse",   32'(d_ready),        32'd0);
      check("st_idle_valid",    32'(mem_in_valid),   32'd0);

      // load 36
      @(posedge clk); #1; d_valid = 1'b1;
      wait_ready(1'b1, 32'd36, cyc, data, aok);
      check("ld_latency",       32'(cyc),            32'd2);
      check("ld_rdata",         data,                32'hefefefef);
      check("ld_mem_out_valid", 32'(mem_out_valid),  32'd1);
      @(posedge clk); #1; d_valid = 1'b0;

      // store 0x40 <- 0x12345678
      @(posedge clk); #1;
      d_addr = 32'h40; d_wdata = 32'h12345678; d_we = 1'b1; d_valid = 1'b1;
      wait_ready(1'b1, 32'h40, cyc, data, aok);
      check("st40_latency",     32'(cyc),            32'd2);
      @(posedge clk); #1; d_valid = 1'b0; d_we = 1'b0;

      // 2-cycle memory fetch from 0x40
      lat = 2;
      @(posedge clk); #1; if_addr = 32'h40; if_valid = 1'b1;
      wait_ready(1'b0, 32'h40, cyc, data, aok);
      check("f2_latency",       32'(cyc),            32'd3);
      check("f2_data",          data,                32'h12345678);
      check("f2_addr_stable",   32'(aok),            32'd1);
      @(posedge clk); #1; if_valid = 1'b0;

      // 3-cycle fetch, data inputs change mid-transaction, stray write-port ready
      lat = 3; force_in_rdy = 1'b1;
      @(posedge clk); #1; if_valid = 1'b1;
      @(posedge clk); #1; d_addr = 32'h999; d_wdata = 32'h55555555; d_we = 1'b1;
      wait_ready(1'b0, 32'h40, cyc, data, aok);
      check("f3_latency",       32'(cyc),            32'd3);
      check("f3_data",          data,                32'h12345678);
      check("f3_addr_stable",   32'(aok),            32'd1);
      check("f3_mem_in_valid",  32'(mem_in_valid),   32'd0);
      @(posedge clk); #1; if_valid = 1'b0; force_in_rdy = 1'b0; d_we = 1'b0;

      // load with valid dropped mid-transaction still completes
      @(posedge clk); #1; d_addr = 32'd36; d_valid = 1'b1;
      @(posedge clk); #1; d_valid = 1'b0;
      wait_ready(1'b1, 32'd36, cyc, data, aok);
      check("drop_latency",     32'(cyc),            32'd3);
      check("drop_rdata",       data,                32'hefefefef);
      @(posedge clk); #1;

      // contention after a reset pulse: round-robin and fixed-priority side by side
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;
      reset = 1'b0; lat = 1;
      if_addr = 32'h40; d_addr = 32'd36; d_we = 1'b0;
      log_en = 1'b1; if_valid = 1'b1; d_valid = 1'b1;
      repeat (14) @(posedge clk); #1; d_valid = 1'b0;
      repeat (6) @(posedge clk); #1; if_valid = 1'b0;
      repeat (6) @(posedge clk); #1; log_en = 1'b0;
      check("rr_grants",        32'(rr_log.size() >= 4), 32'd1);
      if (rr_log.size() >= 4) begin
         check("rr_grant0_data",  32'(rr_log[0]), 32'd1);
         check("rr_grant1_fetch", 32'(rr_log[1]), 32'd0);
         check("rr_grant2_data",  32'(rr_log[2]), 32'd1);
         check("rr_grant3_fetch", 32'(rr_log[3]), 32'd0);
      end
      check("fp_data_grants",   32'(fp_d_cnt >= 4),  32'd1);
      check("fp_fetch_starved", 32'(fp_if_while_dv), 32'd0);
      check("fp_fetch_after",   32'(fp_if_cnt >= 1), 32'd1);
      check("no_overlap_cont",  32'(overlap_seen),   32'd0);

      // reset in the middle of a store
      lat = 4;
      d_addr = 32'h80; d_wdata = 32'hdeadbeef; d_we = 1'b1; d_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rs_in_store",      32'(mem_in_valid),   32'd1);
      snap = d_cnt;
      reset = 1'b1;
      #1;
      check("rs_mem_in_valid",  32'(mem_in_valid),   32'd0);
      check("rs_mem_out_valid", 32'(mem_out_valid),  32'd0);
      check("rs_d_ready",       32'(d_ready),        32'd0);
      check("rs_mem_in_addr",   mem_in_addr,         32'd0);
      check("rs_mem_in_data",   mem_in_data,         32'd0);
      d_valid = 1'b0; d_we = 1'b0;
      repeat (2) @(posedge clk); #1; reset = 1'b0;
      repeat (4) @(posedge clk); #1;
      check("rs_no_d_ready",    32'(d_cnt),          32'(snap));

      // fetch after release
      lat = 1; if_addr = 32'd36; if_valid = 1'b1;
      wait_ready(1'b0, 32'd36, cyc, data, aok);
      check("rs_fetch_latency", 32'(cyc),            32'd2);
      check("rs_fetch_data",    data,                32'hefefefef);
      @(posedge clk); #1; if_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("no_overlap_all",   32'(overlap_seen),   32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
